// File: rtl/sysid_arb_pkg.sv
// Shared types and constants for the system-ID access arbiter.
package sysid_arb_pkg;

  typedef enum logic [2:0] {
    BOOT_ISSUE,
    BOOT_WAIT,
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic        ADDR_ID             = 1'b1;
  localparam logic        ADDR_TS             = 1'b0;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h5EDAF1B3;

endpackage

// File: rtl/sysid_access_arbiter_rr.sv
// Combinational round-robin picker: one-hot winner, search starting at ptr_i and wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_access_arbiter.sv
// Round-robin arbiter sharing a two-word system-ID slave among NUM_REQ requesters.
// Optional boot ID check built when SYSID_BOOT_CHECK_EN is defined.
module sysid_access_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned RD_LATENCY  = 0,
  parameter logic [31:0] EXPECTED_ID = DEFAULT_EXPECTED_ID
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rvalid,
  output logic [31:0]        rdata,
  output logic               m_address,
  output logic               m_read,
  input  logic [31:0]        m_readdata,
  output logic               id_ok,
  output logic               id_err
);

  localparam int unsigned PW  = $clog2(NUM_REQ);
  localparam logic [1:0]  LAT = 2'(RD_LATENCY);

  arb_state_e         state_q;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] win_d;
  logic [NUM_REQ-1:0] gnt_q, rvalid_q;
  logic [31:0]        rdata_q;
  logic               m_read_q, m_addr_q;
  logic [1:0]         cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (win_d)
  );

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_d[k]) ptr_d = PW'((k + 1) % NUM_REQ);
    end
  end

`ifdef SYSID_BOOT_CHECK_EN
  logic id_ok_q, id_err_q;
  assign id_ok  = id_ok_q;
  assign id_err = id_err_q;
`else
  assign id_ok  = 1'b0;
  assign id_err = 1'b0;
`endif

  // Reset parks the FSM in IDLE; with the boot check built, IDLE diverts to
  // BOOT_ISSUE until a result flag is set, so the flags double as "boot done".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      m_read_q <= 1'b0;
      m_addr_q <= ADDR_TS;
      cnt_q    <= '0;
`ifdef SYSID_BOOT_CHECK_EN
      id_ok_q  <= 1'b0;
      id_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef SYSID_BOOT_CHECK_EN
          if (!(id_ok_q || id_err_q)) begin
            state_q  <= BOOT_ISSUE;
            m_read_q <= 1'b1;
            m_addr_q <= ADDR_ID;
          end else
`endif
          if (|req) begin
            state_q  <= ISSUE;
            gnt_q    <= win_d;
            ptr_q    <= ptr_d;
            m_read_q <= 1'b1;
            m_addr_q <= |(win_d & req_addr);
          end
        end
        ISSUE: begin
          m_read_q <= 1'b0;
          cnt_q    <= 2'd1;
          if (RD_LATENCY == 0) begin
            rdata_q  <= m_readdata;
            rvalid_q <= gnt_q;
            state_q  <= RESP;
          end else begin
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == LAT) begin
            rdata_q  <= m_readdata;
            rvalid_q <= gnt_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          rvalid_q <= '0;
          gnt_q    <= '0;
          state_q  <= IDLE;
        end
`ifdef SYSID_BOOT_CHECK_EN
        BOOT_ISSUE: begin
          m_read_q <= 1'b0;
          cnt_q    <= 2'd1;
          if (RD_LATENCY == 0) begin
            id_ok_q  <= (m_readdata == EXPECTED_ID);
            id_err_q <= (m_readdata != EXPECTED_ID);
            state_q  <= IDLE;
          end else begin
            state_q  <= BOOT_WAIT;
          end
        end
        BOOT_WAIT: begin
          if (cnt_q == LAT) begin
            id_ok_q  <= (m_readdata == EXPECTED_ID);
            id_err_q <= (m_readdata != EXPECTED_ID);
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign m_read    = m_read_q;
  assign m_address = m_addr_q;

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Bench: three arbiters (RD_LATENCY 0/2/3) against a transaction-level reference model.
module tb_sysid_access_arbiter;
  import sysid_arb_pkg::*;

  localparam int N  = 4;
  localparam int NI = 3;
  localparam int LAT [NI] = '{0, 2, 3};
  localparam logic [31:0] SLV_ID [NI] = '{32'h5EDAF1B3, 32'h12345678, 32'h5EDAF1B3};
`ifdef SYSID_BOOT_CHECK_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_addr = '0;
  logic [N-1:0] gnt_w [NI];
  logic [N-1:0] rvalid_w [NI];
  logic [31:0]  rdata_w [NI];
  logic [31:0]  sdata [NI];
  logic         maddr_w [NI];
  logic         mread_w [NI];
  logic         idok_w [NI];
  logic         iderr_w [NI];
  int cyc;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sysid_access_arbiter #(.NUM_REQ(N), .RD_LATENCY(0)) u_l0 (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_w[0]), .rvalid(rvalid_w[0]), .rdata(rdata_w[0]),
    .m_address(maddr_w[0]), .m_read(mread_w[0]), .m_readdata(sdata[0]),
    .id_ok(idok_w[0]), .id_err(iderr_w[0]));
  sysid_access_arbiter #(.NUM_REQ(N), .RD_LATENCY(2)) u_l2 (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_w[1]), .rvalid(rvalid_w[1]), .rdata(rdata_w[1]),
    .m_address(maddr_w[1]), .m_read(mread_w[1]), .m_readdata(sdata[1]),
    .id_ok(idok_w[1]), .id_err(iderr_w[1]));
  sysid_access_arbiter #(.NUM_REQ(N), .RD_LATENCY(3)) u_l3 (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_w[2]), .rvalid(rvalid_w[2]), .rdata(rdata_w[2]),
    .m_address(maddr_w[2]), .m_read(mread_w[2]), .m_readdata(sdata[2]),
    .id_ok(idok_w[2]), .id_err(iderr_w[2]));

  // Slave contents: ID word per instance; timestamp word is 0 for instance 1,
  // otherwise tagged with the cycle number of the read strobe.
  function automatic logic [31:0] word(int i, logic a, int c);
    logic [31:0] cv;
    cv = c;
    if (a) return SLV_ID[i];
    return (i == 1) ? 32'h0 : {16'hC0DE, cv[15:0]};
  endfunction

  logic        pv [NI][4];
  logic [31:0] pd [NI][4];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0;
      for (int i = 0; i < NI; i++)
        for (int j = 0; j < 4; j++) begin
          pv[i][j] <= 1'b0;
          pd[i][j] <= '0;
        end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++) begin
        pv[i][0] <= mread_w[i];
        pd[i][0] <= word(i, maddr_w[i], cyc);
        for (int j = 1; j < 4; j++) begin
          pv[i][j] <= pv[i][j-1];
          pd[i][j] <= pd[i][j-1];
        end
      end
    end
  end

  always_comb begin
    sdata[0] = mread_w[0] ? word(0, maddr_w[0], cyc) : 32'hDEADBEEF;
    sdata[1] = pv[1][1] ? pd[1][1] : 32'hDEADBEEF;
    sdata[2] = pv[2][2] ? pd[2][2] : 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction record per instance.
  int          s [NI];
  int          w [NI];
  int          nf [NI];
  int          ptr [NI];
  logic        ta [NI];
  logic [31:0] td [NI];
  logic [31:0] lastrd [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      s[i] = -100; w[i] = 0; ptr[i] = 0; ta[i] = 1'b0; td[i] = '0; lastrd[i] = '0;
      nf[i] = BOOT ? LAT[i] + 2 : 0;
    end
  endtask

  task automatic check_cycle(input int k);
    for (int i = 0; i < NI; i++) begin
      int L;
      logic [31:0] eg, er;
      logic em, eok, eerr;
      L  = LAT[i];
      eg = (k >= s[i] + 1 && k <= s[i] + L + 2) ? (32'(1) << w[i]) : 32'h0;
      er = (k == s[i] + L + 2) ? (32'(1) << w[i]) : 32'h0;
      if (er != 0) lastrd[i] = td[i];
      em   = (k == s[i] + 1) || (BOOT && k == 1);
      eok  = BOOT && k >= L + 2 && SLV_ID[i] == DEFAULT_EXPECTED_ID;
      eerr = BOOT && k >= L + 2 && SLV_ID[i] != DEFAULT_EXPECTED_ID;
      check($sformatf("u%0d.gnt@%0d", i, k), 32'(gnt_w[i]), eg);
      check($sformatf("u%0d.rvalid@%0d", i, k), 32'(rvalid_w[i]), er);
      check($sformatf("u%0d.rdata@%0d", i, k), rdata_w[i], lastrd[i]);
      check($sformatf("u%0d.m_read@%0d", i, k), 32'(mread_w[i]), 32'(em));
      if (k == s[i] + 1)
        check($sformatf("u%0d.m_address@%0d", i, k), 32'(maddr_w[i]), 32'(ta[i]));
      else if (BOOT && k == 1)
        check($sformatf("u%0d.boot_addr@%0d", i, k), 32'(maddr_w[i]), 32'(ADDR_ID));
      check($sformatf("u%0d.id_ok@%0d", i, k), 32'(idok_w[i]), 32'(eok));
      check($sformatf("u%0d.id_err@%0d", i, k), 32'(iderr_w[i]), 32'(eerr));
    end
  endtask

  task automatic sample(input int k);
    for (int i = 0; i < NI; i++) begin
      if (k >= nf[i] && req != 0) begin
        int pick;
        pick = -1;
        for (int j = 0; j < N; j++) begin
          int idx;
          idx = (ptr[i] + j) % N;
          if (pick < 0 && req[idx]) pick = idx;
        end
        w[i]   = pick;
        ptr[i] = (pick + 1) % N;
        s[i]   = k;
        ta[i]  = req_addr[pick];
        td[i]  = word(i, ta[i], k + 1);
        nf[i]  = k + LAT[i] + 3;
      end
    end
  endtask

  task automatic do_cycle(input logic [N-1:0] r, input logic [N-1:0] a);
    int k;
    k = cyc;
    check_cycle(k);
    req = r;
    req_addr = a;
    sample(k);
  endtask

  task automatic reset_zero_check(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.%s.gnt", i, tag), 32'(gnt_w[i]), 32'h0);
      check($sformatf("u%0d.%s.rvalid", i, tag), 32'(rvalid_w[i]), 32'h0);
      check($sformatf("u%0d.%s.rdata", i, tag), rdata_w[i], 32'h0);
      check($sformatf("u%0d.%s.m_read", i, tag), 32'(mread_w[i]), 32'h0);
      check($sformatf("u%0d.%s.m_address", i, tag), 32'(maddr_w[i]), 32'h0);
      check($sformatf("u%0d.%s.id_ok", i, tag), 32'(idok_w[i]), 32'h0);
      check($sformatf("u%0d.%s.id_err", i, tag), 32'(iderr_w[i]), 32'h0);
    end
  endtask

  function automatic logic [N-1:0] rnd_req();
    if ($urandom_range(0, 3) == 0) return '0;
    return N'($urandom_range(0, (1 << N) - 1));
  endfunction

  function automatic bit in_wait(int i, int k);
    return (k >= s[i] + 2) && (k <= s[i] + 1 + LAT[i]);
  endfunction

  initial begin
    bit hit;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      reset_zero_check("por");
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    do_cycle('1, '1);

    repeat (16) begin
      @(negedge clock);
      do_cycle('1, '1);
    end
    repeat (60) begin
      @(negedge clock);
      do_cycle(rnd_req(), N'($urandom_range(0, (1 << N) - 1)));
    end

    // Single-cycle pulse on requester 2 reading the timestamp word.
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clock);
      if (cyc >= nf[1] && cyc >= nf[0] && cyc >= nf[2]) begin
        do_cycle(4'b0100, 4'b0000);
        hit = 1'b1;
      end else begin
        do_cycle('0, '0);
      end
    end
    check("pulse_slot_found", 32'(hit), 32'h1);
    repeat (8) begin
      @(negedge clock);
      do_cycle('0, '0);
    end

    // Reset while the latency-3 instance is waiting on read data.
    hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge clock);
      if (in_wait(2, cyc)) begin
        check_cycle(cyc);
        hit = 1'b1;
      end else begin
        do_cycle(4'b1111, N'($urandom_range(0, (1 << N) - 1)));
      end
    end
    check("wait_state_found", 32'(hit), 32'h1);
    reset_n = 1'b0;
    #1;
    reset_zero_check("async");
    repeat (2) begin
      @(negedge clock);
      reset_zero_check("held");
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    do_cycle('1, N'($urandom_range(0, (1 << N) - 1)));

    repeat (16) begin
      @(negedge clock);
      do_cycle('1, N'($urandom_range(0, (1 << N) - 1)));
    end
    repeat (40) begin
      @(negedge clock);
      do_cycle(rnd_req(), N'($urandom_range(0, (1 << N) - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_access_arbiter.md
SYSID_ACCESS_ARBITER -- requirements
Module: sysid_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter RD_LATENCY, default 0: slave readdata latency in cycles after m_read, range 0..3.
REQ-003 Parameter EXPECTED_ID, default 32'h5EDAF1B3: system ID value the boot check compares against.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester read request, level.
REQ-007 req_addr  in  NUM_REQ  per-requester 1-bit slave word address.
REQ-008 gnt  out  NUM_REQ  one-hot grant, high for the whole granted transaction.
REQ-009 rvalid  out  NUM_REQ  one-hot, one-cycle pulse; read data returned to that requester.
REQ-010 rdata  out  32  shared read data, valid when any rvalid bit is high.
REQ-011 m_address  out  1  slave address; 1 = ID word, 0 = timestamp word.
REQ-012 m_read  out  1  slave read strobe, one cycle per access.
REQ-013 m_readdata  in  32  slave read data.
REQ-014 id_ok / id_err  out  1 each  boot check result, sticky until reset.

Function
REQ-015 FSM states: BOOT_ISSUE, BOOT_WAIT, IDLE, ISSUE, WAIT, RESP.
REQ-016 Arbitration occurs only in IDLE; requests arriving in other states wait, unserviced, until the next IDLE.
REQ-017 Round-robin: search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0; after reset, index 0 has highest priority.
REQ-018 When req is sampled in IDLE at cycle N: at N+1 (ISSUE) m_read=1, m_address=latched req_addr, winner gnt=1.
REQ-019 m_readdata is captured at cycle N+1+RD_LATENCY (same cycle as m_read when RD_LATENCY=0).
REQ-020 RESP is the cycle after capture: rdata=captured value, rvalid bit=winner, gnt deasserts after RESP, return to IDLE.
REQ-021 Request-to-rvalid latency is exactly RD_LATENCY+2 cycles; at most one transaction is outstanding.
REQ-022 A granted transaction completes even if its req drops; an ungranted req that drops is dropped silently.
REQ-023 With no req in IDLE: m_read=0, gnt=0, and the round-robin pointer is unchanged.
REQ-024 rdata holds its last value between responses.

Reset
REQ-025 Async assertion of reset_n forces gnt=0, rvalid=0, m_read=0, m_address=0, rdata=0, id_ok=0, id_err=0, pointer=0, and the FSM to its entry state, including mid-transaction; no pending rvalid is delivered after reset.
REQ-026 After deassertion, the first active edge enters BOOT_ISSUE (macro defined) or IDLE (macro undefined).

Configuration
REQ-027 Macro SYSID_BOOT_CHECK_EN defined: BOOT_ISSUE reads address 1, BOOT_WAIT captures after RD_LATENCY, then sets id_ok=1 if data==EXPECTED_ID else id_err=1, then enters IDLE.
REQ-028 During the boot check, gnt=0 and requests wait.
REQ-029 Macro undefined: BOOT states are not built, and id_ok and id_err are tied 0.

Structure
REQ-030 The shared package sysid_arb_pkg holds: the FSM state enum, ADDR_ID=1'b1, ADDR_TS=1'b0, and the default EXPECTED_ID.
REQ-031 One sub-module, rr_arbiter, is parameterised by NUM_REQ and provides req vector + pointer -> one-hot winner, combinational.
REQ-032 The RD_LATENCY capture counter is local to the top module.

Verification
REQ-033 Macro on, slave returns 0x5EDAF1B3 at address 1 -> one boot m_read with m_address=1; id_ok=1, id_err=0; no gnt during boot.
REQ-034 Macro on, slave returns 0x12345678 -> id_err=1, id_ok=0; arbiter then serves requests normally.
REQ-035 RD_LATENCY=0, req=4'b1111 held, all req_addr=1 -> rvalid order 0,1,2,3,0; each rdata=0x5EDAF1B3; rvalid every 3 cycles.
REQ-036 RD_LATENCY=2, req[2] pulsed one cycle in IDLE with req_addr=0 -> m_read at N+1 with address 0; rvalid[2] at N+4; rdata=0.
REQ-037 reset_n asserted in WAIT with RD_LATENCY=3 -> all outputs 0 immediately; no rvalid after release; boot check reruns.
REQ-038 Macro off -> first req serviced right after reset; id_ok=id_err=0 throughout.
